// File: rtl/nn_fp_pkg.sv
// Shared FP32 constants, MAC state encoding and rounding helpers
// for the neuron datapath.
package nn_fp_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_FOUR = 32'h4080_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [30:0] FP_INF  = 31'h7F80_0000;

  localparam int EXC_NX = 0;
  localparam int EXC_UF = 1;
  localparam int EXC_OF = 2;
  localparam int EXC_DZ = 3;
  localparam int EXC_NV = 4;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    LASTP,
    BIAS,
    DONE
  } mac_state_t;

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    lzc48 = 6'd48;
    for (int i = 0; i < 48; i++)
      if (v[i]) lzc48 = 6'(47 - i);
  endfunction

  // m = {hidden, frac[22:0], guard, round, sticky}; returns {exc, result}
  function automatic logic [36:0] fp_round(
    input logic              s,
    input logic signed [11:0] e_in,
    input logic [26:0]       m_in,
    input logic [2:0]        rm
  );
    logic signed [11:0] e;
    logic [26:0] m;
    logic [11:0] sh;
    logic tiny, g, rs, nx, inc, maxf;
    logic [24:0] mr;
    logic [32:0] t;
    logic [31:0] y;
    logic [4:0]  x;
    e = e_in;
    m = m_in;
    tiny = 1'b0;
    sh = '0;
    if (e < 12'sd1) begin
      sh = 12'(12'sd1 - e);
      tiny = 1'b1;
      if (sh > 12'd26) m = {26'd0, |m_in};
      else m = (m_in >> sh)
             | {26'd0, |(m_in & ~(27'h7FF_FFFF << sh))};
      e = 12'sd1;
    end
    g  = m[2];
    rs = m[1] | m[0];
    nx = g | rs;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s & nx;
      RM_RUP:  inc = !s & nx;
      RM_RMM:  inc = g;
      default: inc = g & (rs | m[3]);
    endcase
    mr = {1'b0, m[26:3]} + 25'(inc);
    // hidden bit carries straight into the exponent field
    t = (33'(e - 12'sd1) << 23) + 33'(mr);
    maxf = (rm == RM_RTZ) | ((rm == RM_RDN) & !s)
         | ((rm == RM_RUP) & s);
    x = '0;
    if (t >= 33'h7F80_0000) begin
      y = {s, maxf ? 31'h7F7F_FFFF : FP_INF};
      x[EXC_OF] = 1'b1;
      x[EXC_NX] = 1'b1;
    end else begin
      y = {s, t[30:0]};
      x[EXC_NX] = nx;
      x[EXC_UF] = tiny & nx;
    end
    return {x, y};
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational IEEE-754 single adder/subtractor with dynamic
// rounding and {NV,DZ,OF,UF,NX} flags.
module add_sub
  import nn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic [2:0]  round_mode,
  output logic [31:0] y,
  output logic [4:0]  exc
);

  logic sa, sb, sx, sy, swap;
  logic na, nb, sna, snb, ia, ib, za, zb;
  logic [7:0]  ex, ey, d;
  logic [23:0] mx, my;
  logic [26:0] bm, bs;
  logic [27:0] sum, nrm;
  logic [5:0]  lz;
  logic signed [11:0] e;
  logic [36:0] r;

  always_comb begin
    sa  = a[31];
    sb  = b[31] ^ sub;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    sna = na & !a[22];
    snb = nb & !b[22];
    ia  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    ib  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    za  = (a[30:0] == '0);
    zb  = (b[30:0] == '0);
    swap = b[30:0] > a[30:0];
    sx = swap ? sb : sa;
    sy = swap ? sa : sb;
    mx = swap ? {b[30:23] != '0, b[22:0]} : {a[30:23] != '0, a[22:0]};
    my = swap ? {a[30:23] != '0, a[22:0]} : {b[30:23] != '0, b[22:0]};
    ex = swap ? b[30:23] : a[30:23];
    ey = swap ? a[30:23] : b[30:23];
    if (ex == '0) ex = 8'd1;
    if (ey == '0) ey = 8'd1;
    d  = ex - ey;
    bm = {my, 3'b000};
    if (d > 8'd26) bs = {26'd0, |bm};
    else bs = (bm >> d) | {26'd0, |(bm & ~(27'h7FF_FFFF << d))};
    sum = (sx == sy) ? ({1'b0, mx, 3'b000} + {1'b0, bs})
                     : ({1'b0, mx, 3'b000} - {1'b0, bs});
    lz  = lzc48({sum, 20'd0});
    nrm = sum << lz;
    e   = $signed({4'd0, ex}) + 12'sd1 - $signed({6'd0, lz});
    r   = fp_round(sx, e, {nrm[27:2], |nrm[1:0]}, round_mode);
    y   = r[31:0];
    exc = r[36:32];
    if (na | nb | (ia & ib & (sa != sb))) begin
      y = FP_QNAN;
      exc = '0;
      exc[EXC_NV] = sna | snb | (ia & ib);
    end else if (ia | ib) begin
      y = {ia ? sa : sb, FP_INF};
      exc = '0;
    end else if (sum == '0) begin
      y = (za & zb & (sa == sb)) ? {sa, 31'd0}
                                 : {round_mode == RM_RDN, 31'd0};
      exc = '0;
    end
  end

endmodule

// File: rtl/fp_clamp.sv
// Clamps an FP32 magnitude to 4.0, sign kept; NaN passes through.
module fp_clamp
  import nn_fp_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  logic big;

  assign big = (a[30:0] >= FP_FOUR[30:0]) && (a[30:0] <= FP_INF);
  assign y   = big ? {a[31], FP_FOUR[30:0]} : a;

endmodule

// File: rtl/multiplier.sv
// Combinational IEEE-754 single multiplier with dynamic rounding
// and {NV,DZ,OF,UF,NX} flags.
module multiplier
  import nn_fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24
) (
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] a,
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] b,
  input  logic [2:0]                      round_mode,
  output logic [EXP_WIDTH+MANT_WIDTH-1:0] y,
  output logic [4:0]                      exc
);

  logic sy, na, nb, sna, snb, ia, ib, za, zb, inv;
  logic [7:0]  ea, eb;
  logic [47:0] prod, pn;
  logic [5:0]  lz;
  logic signed [11:0] e;
  logic [36:0] r;

  always_comb begin
    sy  = a[31] ^ b[31];
    na  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    sna = na & !a[22];
    snb = nb & !b[22];
    ia  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    ib  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    za  = (a[30:0] == '0);
    zb  = (b[30:0] == '0);
    inv = (ia & zb) | (za & ib);
    ea  = (a[30:23] == '0) ? 8'd1 : a[30:23];
    eb  = (b[30:23] == '0) ? 8'd1 : b[30:23];
    prod = {24'd0, a[30:23] != '0, a[22:0]}
         * {24'd0, b[30:23] != '0, b[22:0]};
    lz  = lzc48(prod);
    pn  = prod << lz;
    e   = $signed({4'd0, ea}) + $signed({4'd0, eb})
        - 12'sd126 - $signed({6'd0, lz});
    r   = fp_round(sy, e, {pn[47:22], |pn[21:0]}, round_mode);
    y   = r[31:0];
    exc = r[36:32];
    if (na | nb | inv) begin
      y = FP_QNAN;
      exc = '0;
      exc[EXC_NV] = sna | snb | inv;
    end else if (ia | ib) begin
      y = {sy, FP_INF};
      exc = '0;
    end else if (za | zb) begin
      y = {sy, 31'd0};
      exc = '0;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential FP32 dot product + bias feeding the sigmoid stage.
// Define NEURON_MAC_CLAMP_EN to clamp out_z to +/-4.0.
module neuron_mac
  import nn_fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24,
  parameter int MAX_LEN    = 256,
  localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       round_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_w,
  input  logic             in_last,
  input  logic [31:0]      bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [4:0]       out_exc,
  output logic [CNT_W-1:0] out_len
);

  mac_state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, p_q, p_d, bias_q, bias_d;
  logic [4:0]  exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [2:0]  rm_q, rm_d, mul_rm;
  logic        pv_q, pv_d, hs, last;
  logic [31:0] mul_y, add_b, add_y;
  logic [4:0]  mul_exc, add_exc;

  assign mul_rm = (state_q == IDLE) ? round_mode : rm_q;
  assign add_b  = (state_q == BIAS) ? bias_q : p_q;

  multiplier #(
    .EXP_WIDTH (EXP_WIDTH),
    .MANT_WIDTH(MANT_WIDTH)
  ) u_mul (
    .a         (in_x),
    .b         (in_w),
    .round_mode(mul_rm),
    .y         (mul_y),
    .exc       (mul_exc)
  );

  add_sub u_add (
    .a         (acc_q),
    .b         (add_b),
    .sub       (1'b0),
    .round_mode(rm_q),
    .y         (add_y),
    .exc       (add_exc)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    p_d     = p_q;
    bias_d  = bias_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    rm_d    = rm_q;
    pv_d    = 1'b0;
    in_ready = rst_n & ((state_q == IDLE) | (state_q == ACCUM));
    hs     = in_valid & in_ready;
    cnt_nx = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    // a full vector ends regardless of in_last
    last   = in_last | (cnt_nx == CNT_W'(MAX_LEN));
    unique case (state_q)
      IDLE: if (hs) begin
        acc_d = FP_ZERO;
        exc_d = mul_exc;
        cnt_d = cnt_nx;
        rm_d  = round_mode;
        p_d   = mul_y;
        pv_d  = 1'b1;
        if (last) bias_d = bias;
        state_d = last ? LASTP : ACCUM;
      end
      ACCUM: begin
        if (pv_q) begin
          acc_d = add_y;
          exc_d = exc_d | add_exc;
        end
        if (hs) begin
          p_d   = mul_y;
          pv_d  = 1'b1;
          cnt_d = cnt_nx;
          exc_d = exc_d | mul_exc;
          if (last) begin
            bias_d  = bias;
            state_d = LASTP;
          end
        end
      end
      LASTP: begin
        acc_d   = add_y;
        exc_d   = exc_q | add_exc;
        state_d = BIAS;
      end
      BIAS: begin
        acc_d   = add_y;
        exc_d   = exc_q | add_exc;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_ZERO;
      p_q     <= FP_ZERO;
      bias_q  <= FP_ZERO;
      exc_q   <= '0;
      cnt_q   <= '0;
      rm_q    <= RM_RNE;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      bias_q  <= bias_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
      rm_q    <= rm_d;
      pv_q    <= pv_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_exc   = exc_q;
  assign out_len   = cnt_q;

`ifdef NEURON_MAC_CLAMP_EN
  fp_clamp u_clamp (
    .a(acc_q),
    .y(out_z)
  );
`else
  assign out_z = acc_q;
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// Directed-vector bench for neuron_mac (MAX_LEN=4) with
// hand-computed FP32 results.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  round_mode = 3'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_w = '0;
  logic        in_last = 1'b0;
  logic [31:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_z;
  logic [4:0]  out_exc;
  logic [2:0]  out_len;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_mac #(.MAX_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .round_mode(round_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_exc   (out_exc),
    .out_len   (out_len)
  );

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] FOUR = 32'h4080_0000;
`ifdef NEURON_MAC_CLAMP_EN
  localparam logic [31:0] Z_FIVE = FOUR;
  localparam logic [31:0] Z_INF  = FOUR;
`else
  localparam logic [31:0] Z_FIVE = 32'h40A0_0000;
  localparam logic [31:0] Z_INF  = 32'h7F80_0000;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // returns 1ns after the accepting edge
  task automatic send(input logic [31:0] x, input logic [31:0] w,
                      input logic lst, input logic [31:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    in_last = lst;
    bias = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] ez,
                      input logic [4:0] eexc, input logic [2:0] elen,
                      input int elat, input int hold);
    int lat;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (elat >= 0) check({tag, "_lat"}, lat, elat);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_z"}, out_z, ez);
    check({tag, "_exc"}, {27'd0, out_exc}, {27'd0, eexc});
    check({tag, "_len"}, {29'd0, out_len}, {29'd0, elen});
    check({tag, "_rdy_lo"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_z"}, out_z, ez);
      check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_hi"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int nacc;
    #1;
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_z", out_z, 32'd0);
    check("rst_exc", {27'd0, out_exc}, 32'd0);
    check("rst_len", {29'd0, out_len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_rdy", {31'd0, in_ready}, 32'd1);

    // 1*0.5 + 2*0.5 + 3*0.5 + 1 = 4.0
    send(ONE, 32'h3F00_0000, 1'b0, 32'd0);
    send(32'h4000_0000, 32'h3F00_0000, 1'b0, 32'd0);
    send(32'h4040_0000, 32'h3F00_0000, 1'b1, ONE);
    recv("dot3", FOUR, 5'd0, 3'd3, 2, 0);

    // 2*3 - 1 = 5.0
    send(32'h4000_0000, 32'h4040_0000, 1'b1, 32'hBF80_0000);
    recv("single", Z_FIVE, 5'd0, 3'd1, 2, 0);

    send(ONE, ONE, 1'b1, 32'd0);
    recv("hold", ONE, 5'd0, 3'd1, 2, 5);

    // 2^127 * 2 overflows: OF|NX
    send(32'h7F00_0000, 32'h4000_0000, 1'b1, 32'd0);
    recv("ovf", Z_INF, 5'h05, 3'd1, 2, 0);
    send(ONE, ONE, 1'b1, 32'd0);
    recv("exc_clr", ONE, 5'd0, 3'd1, 2, 0);

    send(ONE, ONE, 1'b0, 32'd0);
    send(ONE, ONE, 1'b0, 32'd0);
    check("mid_len", {29'd0, out_len}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_z", out_z, 32'd0);
    check("mid_rst_len", {29'd0, out_len}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(ONE, ONE, 1'b1, 32'd0);
    recv("post_rst", ONE, 5'd0, 3'd1, 2, 0);

    // six beats offered, fourth one is forced last
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = ONE;
      in_w = ONE;
      in_last = 1'b0;
      bias = 32'd0;
      if (in_ready) nacc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("sat_beats", nacc, 4);
    recv("sat", FOUR, 5'd0, 3'd4, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
